// File: rtl/props_pkg.sv
// Shared definitions for the prop event queue.
// Holds the tank count, the Avalon register addresses, the event-type encoding,
// the layout of a queued event word, the ack FSM state encoding and the
// lowest-active-index helper.
package props_pkg;

    localparam int unsigned TANK_NUM = 2;

    localparam logic [11:0] EVENT_REG_ADDR      = 12'd2089;
    localparam logic [11:0] EVT_STATUS_REG_ADDR = 12'd2090;

    typedef enum logic [1:0] {
        EvtNone  = 2'b00,
        EvtCure  = 2'b01,
        EvtSpeed = 2'b10
    } evt_type_e;

    // Software-visible event layout; reserved fields read back as zero.
    typedef struct packed {
        logic       valid;    // [31]
        logic [6:0] rsvd_hi;  // [30:24]
        logic [15:0] ts;      // [23:8]
        logic [3:0] idx;      // [7:4]
        logic [1:0] rsvd_lo;  // [3:2]
        evt_type_e  etype;    // [1:0]
    } event_word_t;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StCureAck   = 3'd1,
        StCureWait  = 3'd2,
        StSpeedAck  = 3'd3,
        StSpeedWait = 3'd4
    } ack_state_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] lowest_index(input logic [15:0] flags);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (flags[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prop_event_fifo.sv
// Event FIFO for the prop event queue.
// Ports:
//   clk_i, rst_ni        clock and synchronous active-low reset
//   push_i, wdata_i      write request and data; accepted when not full or when
//                        a pop happens in the same cycle
//   pop_i                read request; ignored when empty
//   rdata_o              head entry (valid when not empty)
//   full_o, empty_o      occupancy flags
//   count_o              number of stored entries (0..DEPTH)
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module prop_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO still fits.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/prop_event_queue.sv
// Prop contact acknowledger with timestamped event queue.
// Ports:
//   CLK, Reset          clock and synchronous active-low reset
//   to_cure, to_speed   per-tank prop contact flags
//   AVL_*               Avalon-MM slave: EVENT (2089, read pops) and STATUS (2090)
//   cured, speed_up     one-cycle ack pulses that clear the prop registers
//   irq                 level interrupt: irq_en and (queue non-empty or overflow)
// Each accepted contact is acked with a one-cycle pulse followed by one wait
// cycle, and a 32-bit event word is queued for software.
module prop_event_queue #(
    parameter int unsigned TANK_NUM   = props_pkg::TANK_NUM,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [TANK_NUM-1:0] to_cure,
    input  logic [TANK_NUM-1:0] to_speed,
    input  logic                AVL_READ,
    input  logic                AVL_WRITE,
    input  logic [11:0]         AVL_ADDR,
    input  logic [31:0]         AVL_WRITEDATA,
    output logic [31:0]         AVL_READDATA,
    output logic                cured,
    output logic                speed_up,
    output logic                irq
);

    import props_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0] ts_q, ts_d;
    ack_state_e  state_q, state_d;
    logic        cured_q, cured_d;
    logic        speed_q, speed_d;
    logic        ovf_q, ovf_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] rdata_q, rdata_d;

    event_word_t evt;
    logic        push, pop, drop, fifo_full, fifo_empty;
    logic        rd_event, wr_status;
    logic [31:0] fifo_head, status_word;
    logic [CW-1:0] fifo_count;
    logic        unused_wdata;

    assign unused_wdata = ^{AVL_WRITEDATA[31:17], AVL_WRITEDATA[15:9], AVL_WRITEDATA[7:0]};

    assign rd_event  = AVL_READ && (AVL_ADDR == EVENT_REG_ADDR);
    assign wr_status = AVL_WRITE && (AVL_ADDR == EVT_STATUS_REG_ADDR);
    assign pop       = rd_event && !fifo_empty;
    assign drop      = push && fifo_full && !pop;

    assign status_word = {15'd0, irq_en_q, 7'd0, ovf_q, 4'd0, 4'(fifo_count)};

    // Ack FSM and event word formation.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        evt       = '0;
        evt.valid = 1'b1;
        evt.ts    = ts_q;
        unique case (state_q)
            StIdle: begin
                if (|to_cure) begin
                    state_d   = StCureAck;
                    push      = 1'b1;
                    evt.idx   = lowest_index(16'(to_cure));
                    evt.etype = EvtCure;
                end else if (|to_speed) begin
                    state_d   = StSpeedAck;
                    push      = 1'b1;
                    evt.idx   = lowest_index(16'(to_speed));
                    evt.etype = EvtSpeed;
                end
            end
            StCureAck:   state_d = StCureWait;
            StCureWait:  state_d = StIdle;
            StSpeedAck:  state_d = StSpeedWait;
            StSpeedWait: state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Register file and bookkeeping.
    always_comb begin
        ts_d     = ts_q + 16'd1;
        cured_d  = (state_d == StCureAck);
        speed_d  = (state_d == StSpeedAck);
        irq_en_d = wr_status ? AVL_WRITEDATA[16] : irq_en_q;

        // Set beats clear so a drop in the clearing cycle is not lost.
        ovf_d = ovf_q;
        if (wr_status && AVL_WRITEDATA[8]) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        rdata_d = 32'd0;
        if (AVL_READ) begin
            if (AVL_ADDR == EVENT_REG_ADDR) begin
                rdata_d = fifo_empty ? 32'd0 : fifo_head;
            end else if (AVL_ADDR == EVT_STATUS_REG_ADDR) begin
                rdata_d = status_word;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            ts_q     <= 16'd0;
            state_q  <= StIdle;
            cured_q  <= 1'b0;
            speed_q  <= 1'b0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            ts_q     <= ts_d;
            state_q  <= state_d;
            cured_q  <= cured_d;
            speed_q  <= speed_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
        end
    end

    prop_event_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk_i  (CLK),
        .rst_ni (Reset),
        .push_i (push),
        .wdata_i(evt),
        .pop_i  (pop),
        .rdata_o(fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    assign AVL_READDATA = rdata_q;
    assign cured        = cured_q;
    assign speed_up     = speed_q;
    assign irq          = irq_en_q && ((fifo_count != '0) || ovf_q);

endmodule

// File: tb/tb_prop_event_queue.sv
module tb_prop_event_queue;

    localparam logic [11:0] A_EVT = 12'd2089;
    localparam logic [11:0] A_STS = 12'd2090;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  to_cure = '0;
    logic [1:0]  to_speed = '0;
    logic        AVL_READ = 1'b0;
    logic        AVL_WRITE = 1'b0;
    logic [11:0] AVL_ADDR = '0;
    logic [31:0] AVL_WRITEDATA = '0;
    logic [31:0] AVL_READDATA;
    logic        cured, speed_up, irq;

    always #5 CLK = ~CLK;

    prop_event_queue #(
        .TANK_NUM(2),
        .FIFO_DEPTH(8)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .to_cure      (to_cure),
        .to_speed     (to_speed),
        .AVL_READ     (AVL_READ),
        .AVL_WRITE    (AVL_WRITE),
        .AVL_ADDR     (AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA (AVL_READDATA),
        .cured        (cured),
        .speed_up     (speed_up),
        .irq          (irq)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of event words plus a lockout countdown.
    int unsigned mq[$];
    bit          m_ovf, m_irqen, m_cured, m_speed;
    int          m_lock;
    logic [31:0] m_rdata;
    int unsigned tcyc;

    task automatic model_edge();
        bit          cure_any, speed_any, idle, ev, pop, drop;
        int unsigned word, idx;
        logic [1:0]  flags;
        if (!Reset) begin
            mq.delete();
            m_ovf = 0; m_irqen = 0; m_cured = 0; m_speed = 0;
            m_lock = 0; m_rdata = 0; tcyc = 0;
            return;
        end
        cure_any  = |to_cure;
        speed_any = |to_speed;
        idle      = (m_lock == 0);
        ev        = idle && (cure_any || speed_any);
        m_rdata   = 0;
        if (AVL_READ) begin
            if (AVL_ADDR == A_EVT) m_rdata = (mq.size() > 0) ? mq[0] : 0;
            else if (AVL_ADDR == A_STS)
                m_rdata = (m_irqen ? 32'h10000 : 0) | (m_ovf ? 32'h100 : 0) | mq.size();
        end
        pop = AVL_READ && (AVL_ADDR == A_EVT) && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        drop = 0;
        if (ev) begin
            flags = cure_any ? to_cure : to_speed;
            idx = 0;
            for (int i = 1; i >= 0; i--) if (flags[i]) idx = i;
            word = 32'h8000_0000 | ((tcyc % 65536) << 8) | (idx << 4) | (cure_any ? 1 : 2);
            if (mq.size() < 8) mq.push_back(word);
            else drop = 1;
        end
        if (AVL_WRITE && AVL_ADDR == A_STS) begin
            m_irqen = AVL_WRITEDATA[16];
            if (AVL_WRITEDATA[8]) m_ovf = 0;
        end
        if (drop) m_ovf = 1;
        m_cured = idle && cure_any;
        m_speed = idle && !cure_any && speed_any;
        if (ev) m_lock = 2;
        else if (m_lock > 0) m_lock--;
        tcyc++;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("m_cured", {31'd0, cured}, {31'd0, m_cured});
        chk("m_speed_up", {31'd0, speed_up}, {31'd0, m_speed});
        chk("m_readdata", AVL_READDATA, m_rdata);
        chk("m_irq", {31'd0, irq}, {31'd0, m_irqen && (mq.size() != 0 || m_ovf)});
    endtask

    task automatic idle_in();
        to_cure = 0; to_speed = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = 0; AVL_WRITEDATA = 0;
    endtask

    task automatic do_reset();
        idle_in();
        Reset = 0;
        repeat (3) step();
        chk("rst_cured", {31'd0, cured}, 0);
        chk("rst_speed", {31'd0, speed_up}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        chk("rst_rdata", AVL_READDATA, 0);
        Reset = 1;
    endtask

    task automatic rd(input logic [11:0] a);
        idle_in(); AVL_READ = 1; AVL_ADDR = a; step(); AVL_READ = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        idle_in(); AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d; step(); AVL_WRITE = 0;
    endtask

    typedef struct {
        logic [1:0]  cure, speed;
        logic        rd, wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        e_cured, e_speed;
        logic [31:0] e_rdata;
        logic        e_irq;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] c, input logic [1:0] s, input logic r,
                                input logic w, input logic [11:0] a, input logic [31:0] d,
                                input logic ec, input logic es, input logic [31:0] er,
                                input logic ei);
        vec_t v;
        v.cure = c; v.speed = s; v.rd = r; v.wr = w; v.addr = a; v.wdata = d;
        v.e_cured = ec; v.e_speed = es; v.e_rdata = er; v.e_irq = ei;
        return v;
    endfunction

    vec_t vecs[13];
    int   npulse;

    initial begin
        // One row per cycle starting at timestamp 0 after reset.
        vecs[0]  = mk(2'b00, 2'b00, 0, 0, 0,     0,          0, 0, 0,          0);
        vecs[1]  = mk(2'b00, 2'b00, 0, 1, A_STS, 32'h10000,  0, 0, 0,          0);
        vecs[2]  = mk(2'b01, 2'b00, 0, 0, 0,     0,          1, 0, 0,          1);
        vecs[3]  = mk(2'b00, 2'b10, 0, 0, 0,     0,          0, 0, 0,          1);
        vecs[4]  = mk(2'b00, 2'b00, 0, 0, 0,     0,          0, 0, 0,          1);
        vecs[5]  = mk(2'b00, 2'b10, 0, 0, 0,     0,          0, 1, 0,          1);
        vecs[6]  = mk(2'b00, 2'b00, 1, 0, A_STS, 0,          0, 0, 32'h10002,  1);
        vecs[7]  = mk(2'b00, 2'b00, 1, 0, A_EVT, 0,          0, 0, 32'h80000201, 1);
        vecs[8]  = mk(2'b00, 2'b00, 1, 0, A_EVT, 0,          0, 0, 32'h80000512, 0);
        vecs[9]  = mk(2'b00, 2'b00, 1, 0, A_EVT, 0,          0, 0, 0,          0);
        vecs[10] = mk(2'b00, 2'b00, 1, 0, 12'd0, 0,          0, 0, 0,          0);
        vecs[11] = mk(2'b00, 2'b00, 0, 1, A_STS, 0,          0, 0, 0,          0);
        vecs[12] = mk(2'b00, 2'b00, 1, 0, A_STS, 0,          0, 0, 0,          0);

        do_reset();
        foreach (vecs[i]) begin
            to_cure = vecs[i].cure; to_speed = vecs[i].speed;
            AVL_READ = vecs[i].rd; AVL_WRITE = vecs[i].wr;
            AVL_ADDR = vecs[i].addr; AVL_WRITEDATA = vecs[i].wdata;
            step();
            chk($sformatf("vec%0d_cured", i), {31'd0, cured}, {31'd0, vecs[i].e_cured});
            chk($sformatf("vec%0d_speed", i), {31'd0, speed_up}, {31'd0, vecs[i].e_speed});
            chk($sformatf("vec%0d_rdata", i), AVL_READDATA, vecs[i].e_rdata);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].e_irq});
        end
        idle_in();

        // Contact at timestamp 0x0010.
        do_reset();
        repeat (16) step();
        to_cure = 2'b10; step();
        chk("ts10_cured", {31'd0, cured}, 1);
        to_cure = 0; step();
        chk("ts10_cured_end", {31'd0, cured}, 0);
        rd(A_EVT); chk("ts10_event", AVL_READDATA, 32'h80001011);
        rd(A_EVT); chk("ts10_empty", AVL_READDATA, 0);

        // Simultaneous contact: cure wins, speed acked three cycles later.
        do_reset();
        to_cure = 2'b01; to_speed = 2'b10; step();
        chk("simul_cured", {31'd0, cured}, 1);
        to_cure = 0; step(); step(); step();
        chk("simul_speed", {31'd0, speed_up}, 1);
        to_speed = 0;
        rd(A_EVT); chk("simul_evt0", AVL_READDATA, 32'h80000001);
        rd(A_EVT); chk("simul_evt1", AVL_READDATA, 32'h80000312);

        // Nine events into an 8-entry queue.
        do_reset();
        npulse = 0;
        for (int k = 0; k < 9; k++) begin
            to_cure = 2'b01; step();
            if (cured) npulse++;
            to_cure = 0; step(); step();
        end
        chk("nine_pulses", npulse, 9);
        rd(A_STS); chk("full_status", AVL_READDATA, 32'h108);
        wr(A_STS, 32'h100);
        rd(A_STS); chk("ovf_cleared", AVL_READDATA, 32'h8);
        // Full queue, pop and push in the same cycle.
        to_cure = 2'b01; AVL_READ = 1; AVL_ADDR = A_EVT; step();
        chk("fullpop_head", AVL_READDATA, 32'h80000001);
        idle_in(); step(); step();
        rd(A_STS); chk("fullpop_status", AVL_READDATA, 32'h8);
        rd(A_EVT); chk("fullpop_next", AVL_READDATA, 32'h80000301);

        // Reset in the middle of an ack with events queued.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            to_cure = 2'b10; step(); to_cure = 0; step(); step();
        end
        to_cure = 2'b01; step();
        chk("midack_cured", {31'd0, cured}, 1);
        to_cure = 0; Reset = 0; step();
        chk("midack_abort", {31'd0, cured}, 0);
        Reset = 1;
        rd(A_STS); chk("midack_status", AVL_READDATA, 0);
        rd(A_EVT); chk("midack_event", AVL_READDATA, 0);

        // Timestamp wrap.
        do_reset();
        while (tcyc != 65535) step();
        to_cure = 2'b01; step(); to_cure = 0; step(); step();
        to_speed = 2'b10; step(); to_speed = 0;
        rd(A_EVT); chk("wrap_evt0", AVL_READDATA, 32'h80FFFF01);
        rd(A_EVT); chk("wrap_evt1", AVL_READDATA, 32'h80000212);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int unsigned p;
            Reset    = ($urandom_range(0, 499) != 0);
            to_cure  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            to_speed = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
            AVL_READ = ($urandom_range(0, 3) == 0);
            AVL_WRITE = ($urandom_range(0, 9) == 0);
            p = $urandom_range(0, 3);
            AVL_ADDR = (p < 2) ? A_EVT : (p == 2) ? A_STS : 12'($urandom);
            if (AVL_WRITE && $urandom_range(0, 1) == 0) AVL_ADDR = A_STS;
            AVL_WRITEDATA = $urandom;
            step();
        end
        Reset = 1;
        idle_in();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
